// File: rtl/usb_hub_pkg.sv
// rtl/usb_hub_pkg.sv - shared USB hub types and line constants; USB_TX_LOW_SPEED_EN selects low-speed polarity
package usb_hub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  // Line states are packed as {plus, minus}.
`ifdef USB_TX_LOW_SPEED_EN
  localparam logic [1:0] USB_LINE_J = 2'b01;
  localparam logic [1:0] USB_LINE_K = 2'b10;
  localparam int USB_DEFAULT_CLKS_PER_BIT = 32;
`else
  localparam logic [1:0] USB_LINE_J = 2'b10;
  localparam logic [1:0] USB_LINE_K = 2'b01;
  localparam int USB_DEFAULT_CLKS_PER_BIT = 4;
`endif
  localparam logic [1:0] USB_LINE_SE0 = 2'b00;

  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;
  localparam int USB_MAX_ONES = 6;
  localparam int USB_EOP_SE0_BITS = 2;

  // Map the NRZI level (1 = J) onto the pad pair.
  function automatic logic [1:0] usb_line_of(input logic lvl_j);
    return lvl_j ? USB_LINE_J : USB_LINE_K;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// rtl/usb_bit_timer.sv - bit-time tick generator with synchronous restart
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic hi_clock,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1; restart pins the count at zero so a bit starts aligned.
  always_ff @(posedge hi_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // tick marks the last cycle of a bit; pre_tick the cycle before it.
  assign tick     = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/usb_phy_tx.sv
// rtl/usb_phy_tx.sv - USB upstream line transmitter (SYNC, NRZI, bit stuffing, EOP); USB_TX_LOW_SPEED_EN selects low speed
module usb_phy_tx
  import usb_hub_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_DEFAULT_CLKS_PER_BIT
) (
  input  logic       hi_clock,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_error,
  output logic       tx_plus,
  output logic       tx_minus,
  output logic       tx_oe
);

  localparam logic [2:0] MAX_ONES = 3'(USB_MAX_ONES);
  localparam logic [1:0] EOP_LAST = 2'(USB_EOP_SE0_BITS - 1);

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic [2:0] ones;
  logic       last_q;
  logic [1:0] eop_cnt;
  logic       lvl_j;

  logic       tick;
  logic       pre_tick;
  logic       xfer;
  logic       in_data;
  logic       at_boundary;
  logic       go_eop;
  logic       launch;
  logic       next_bit;
  logic [2:0] bit_inc;
  logic       nxt_lvl;
  logic [2:0] nxt_ones;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .hi_clock (hi_clock),
    .rst_n    (rst_n),
    .restart  (state == ST_IDLE),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  assign xfer        = tx_valid && tx_ready;
  assign in_data     = (state == ST_DATA) || (state == ST_STUFF);
  assign bit_inc     = bit_idx + 3'd1;
  // Last slot of a byte: bit 7 sent and no stuff bit pending (a trailing stuff slot keeps bit_idx at 7).
  assign at_boundary = in_data && (bit_idx == 3'd7) && (ones != MAX_ONES);
  assign go_eop      = tick && at_boundary && (last_q || !tx_valid);
  assign launch      = ((state == ST_IDLE) && xfer) ||
                       (tick && ((state == ST_SYNC) || in_data) && !go_eop);
  assign nxt_lvl     = next_bit ? lvl_j : ~lvl_j;
  assign nxt_ones    = next_bit ? ones + 3'd1 : 3'd0;

  // Select the bit that occupies the next slot; a stuff bit is a forced 0.
  always_comb begin
    next_bit = 1'b0;
    case (state)
      ST_SYNC: next_bit = (bit_idx == 3'd7) ? shreg[0] : USB_SYNC_BYTE[bit_inc];
      ST_DATA, ST_STUFF: begin
        if (ones == MAX_ONES)       next_bit = 1'b0;
        else if (bit_idx == 3'd7)   next_bit = tx_data[0];
        else                        next_bit = shreg[bit_inc];
      end
      default: next_bit = USB_SYNC_BYTE[0];
    endcase
  end

  // Packet sequencer with registered line, handshake and status outputs.
  always_ff @(posedge hi_clock or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      shreg              <= '0;
      bit_idx            <= '0;
      ones               <= '0;
      last_q             <= 1'b0;
      eop_cnt            <= '0;
      lvl_j              <= 1'b1;
      {tx_plus, tx_minus} <= USB_LINE_J;
      tx_oe              <= 1'b0;
      tx_busy            <= 1'b0;
      tx_ready           <= 1'b1;
      tx_error           <= 1'b0;
    end else begin
      tx_error <= 1'b0;
      tx_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_ready <= !xfer;
          if (xfer) begin
            shreg   <= tx_data;
            last_q  <= tx_last;
            bit_idx <= '0;
            tx_oe   <= 1'b1;
            tx_busy <= 1'b1;
            state   <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (tick) begin
            bit_idx <= bit_inc;
            if (bit_idx == 3'd7) state <= ST_DATA;
          end
        end
        ST_DATA, ST_STUFF: begin
          if (pre_tick) tx_ready <= at_boundary && !last_q;
          if (tick) begin
            if (ones == MAX_ONES) begin
              state <= ST_STUFF;
            end else if (bit_idx != 3'd7) begin
              bit_idx <= bit_inc;
              state   <= ST_DATA;
            end else if (go_eop) begin
              tx_error           <= !last_q;
              eop_cnt            <= '0;
              {tx_plus, tx_minus} <= USB_LINE_SE0;
              state              <= ST_EOP_SE0;
            end else begin
              shreg   <= tx_data;
              last_q  <= tx_last;
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end
        end
        ST_EOP_SE0: begin
          if (tick) begin
            if (eop_cnt == EOP_LAST) begin
              {tx_plus, tx_minus} <= USB_LINE_J;
              state              <= ST_EOP_J;
            end else begin
              eop_cnt <= eop_cnt + 2'd1;
            end
          end
        end
        ST_EOP_J: begin
          if (tick) begin
            lvl_j    <= 1'b1;
            tx_oe    <= 1'b0;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (launch) begin
        lvl_j              <= nxt_lvl;
        ones               <= nxt_ones;
        {tx_plus, tx_minus} <= usb_line_of(nxt_lvl);
      end
    end
  end

endmodule
